// File: rtl/fmul_pipe_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | fmul_pipe_pkg : shared fp32 constants, rounding modes, class decode  |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
package fmul_pipe_pkg;

    localparam logic [30:0] C_ZERO = 31'h00000000;
    localparam logic [30:0] C_INF  = 31'h7f800000;
    localparam logic [30:0] C_NAN  = 31'h7fc00000;
    localparam logic [30:0] C_MAX  = 31'h7f7fffff;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RDN = 2'b01,
        RM_RUP = 2'b10,
        RM_RTZ = 2'b11
    } rm_e;

    typedef struct packed {
        logic exp_zero;
        logic exp_ones;
        logic frac_zero;
    } fp_class_t;

    function automatic fp_class_t fp_classify(input logic [30:0] x);
        fp_class_t c;
        c.exp_zero  = (x[30:23] == 8'h00);
        c.exp_ones  = (x[30:23] == 8'hff);
        c.frac_zero = (x[22:0] == 23'd0);
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fmul_mant24.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | fmul_mant24 : combinational 24x24 -> 48-bit unsigned mantissa product|
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module fmul_mant24 (
    input  logic [23:0] i_a,
    input  logic [23:0] i_b,
    output logic [47:0] o_p
);

    assign o_p = {24'd0, i_a} * {24'd0, i_b};

endmodule
`default_nettype wire

// File: rtl/fp_msb_norm.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_msb_norm : shifts a 24-bit fraction left until its MSB is set     |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module fp_msb_norm (
    input  logic [23:0] i_frac,
    output logic [23:0] o_frac,
    output logic [4:0]  o_shamt
);

    // Highest set bit wins; an all-zero fraction reports a shift of zero.
    always_comb begin
        o_shamt = 5'd0;
        for (int i = 0; i < 24; i++) begin
            if (i_frac[i]) o_shamt = 5'(23 - i);
        end
    end

    assign o_frac = i_frac << o_shamt;

endmodule
`default_nettype wire

// File: rtl/fmul_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | fmul_pipe : three-stage pipelined IEEE-754 single-precision multiply |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module fmul_pipe
    import fmul_pipe_pkg::*;
(
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  rm,
    input  logic        fmul,
    input  logic        enable,
    output logic [31:0] s,
    output logic        s_valid
);

    // ---------------- E1: unpack and normalise ----------------
    fp_class_t   w_cls_a, w_cls_b;
    logic [23:0] w_frac_a, w_frac_b, w_norm_a, w_norm_b;
    logic [4:0]  w_sha, w_shb;
    logic [9:0]  w_exp10;

    assign w_cls_a  = fp_classify(a[30:0]);
    assign w_cls_b  = fp_classify(b[30:0]);
    // Denormals carry the fraction one place up, matching the divider.
    assign w_frac_a = w_cls_a.exp_zero ? {a[22:0], 1'b0} : {1'b1, a[22:0]};
    assign w_frac_b = w_cls_b.exp_zero ? {b[22:0], 1'b0} : {1'b1, b[22:0]};

    fp_msb_norm u_norm_a (.i_frac(w_frac_a), .o_frac(w_norm_a), .o_shamt(w_sha));
    fp_msb_norm u_norm_b (.i_frac(w_frac_b), .o_frac(w_norm_b), .o_shamt(w_shb));

    assign w_exp10 = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd126
                   - {5'd0, w_sha} - {5'd0, w_shb};

    logic        r1_valid, r1_sign;
    rm_e         r1_rm;
    logic [23:0] r1_frac_a, r1_frac_b;
    logic [9:0]  r1_exp;
    fp_class_t   r1_cls_a, r1_cls_b;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r1_valid  <= 1'b0;
            r1_sign   <= 1'b0;
            r1_rm     <= RM_RNE;
            r1_frac_a <= '0;
            r1_frac_b <= '0;
            r1_exp    <= '0;
            r1_cls_a  <= '0;
            r1_cls_b  <= '0;
        end else if (enable) begin
            r1_valid  <= fmul;
            r1_sign   <= a[31] ^ b[31];
            r1_rm     <= rm_e'(rm);
            r1_frac_a <= w_norm_a;
            r1_frac_b <= w_norm_b;
            r1_exp    <= w_exp10;
            r1_cls_a  <= w_cls_a;
            r1_cls_b  <= w_cls_b;
        end
    end

    // ---------------- E2: mantissa product ----------------
    logic [47:0] w_prod;

    fmul_mant24 u_mant (.i_a(r1_frac_a), .i_b(r1_frac_b), .o_p(w_prod));

    logic        r2_valid, r2_sign;
    rm_e         r2_rm;
    logic [47:0] r2_prod;
    logic [9:0]  r2_exp;
    fp_class_t   r2_cls_a, r2_cls_b;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r2_valid <= 1'b0;
            r2_sign  <= 1'b0;
            r2_rm    <= RM_RNE;
            r2_prod  <= '0;
            r2_exp   <= '0;
            r2_cls_a <= '0;
            r2_cls_b <= '0;
        end else if (enable) begin
            r2_valid <= r1_valid;
            r2_sign  <= r1_sign;
            r2_rm    <= r1_rm;
            r2_prod  <= w_prod;
            r2_exp   <= r1_exp;
            r2_cls_a <= r1_cls_a;
            r2_cls_b <= r1_cls_b;
        end
    end

    // ---------------- E3: normalise, round, specials ----------------
    logic [47:0] w_z, w_zs;
    logic [9:0]  w_e, w_shamt, w_exp_fin;
    logic        w_den, w_lost, w_g, w_r, w_st, w_inc, w_ovf;
    logic [23:0] w_mant;
    logic [24:0] w_mant_r;
    logic        w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;
    logic [30:0] w_ovf_mag, w_calc, w_mag;

    always_comb begin
        w_z     = r2_prod[47] ? r2_prod : {r2_prod[46:0], 1'b0};
        w_e     = r2_prod[47] ? r2_exp  : r2_exp - 10'd1;
        w_den   = w_e[9] | (w_e == 10'd0);
        w_shamt = 10'd1 - w_e;
        w_zs    = w_z;
        w_lost  = 1'b0;
        if (w_den) begin
            if (w_shamt >= 10'd26) begin
                w_zs   = '0;
                w_lost = |w_z;
            end else begin
                w_zs   = w_z >> w_shamt[4:0];
                w_lost = |(w_z & ~({48{1'b1}} << w_shamt[4:0]));
            end
        end
        w_mant = w_zs[47:24];
        w_g    = w_zs[23];
        w_r    = w_zs[22];
        w_st   = (|w_zs[21:0]) | w_lost;

        w_inc = 1'b0;
        case (r2_rm)
            RM_RNE:  w_inc = w_g & (w_r | w_st | w_mant[0]);
            RM_RDN:  w_inc = (w_g | w_r | w_st) & r2_sign;
            RM_RUP:  w_inc = (w_g | w_r | w_st) & ~r2_sign;
            default: w_inc = 1'b0;
        endcase

        // A denormal that rounds up to the hidden-bit position becomes exponent 1.
        w_mant_r  = {1'b0, w_mant} + {24'd0, w_inc};
        w_exp_fin = w_den ? {9'd0, w_mant_r[23]} : w_e + {9'd0, w_mant_r[24]};
        w_ovf     = ~w_den & (w_exp_fin > 10'd254);

        w_ovf_mag = C_MAX;
        case (r2_rm)
            RM_RNE:  w_ovf_mag = C_INF;
            RM_RDN:  w_ovf_mag = r2_sign ? C_INF : C_MAX;
            RM_RUP:  w_ovf_mag = r2_sign ? C_MAX : C_INF;
            default: w_ovf_mag = C_MAX;
        endcase
        w_calc = w_ovf ? w_ovf_mag : {w_exp_fin[7:0], w_mant_r[22:0]};

        w_nan_a  = r2_cls_a.exp_ones & ~r2_cls_a.frac_zero;
        w_nan_b  = r2_cls_b.exp_ones & ~r2_cls_b.frac_zero;
        w_inf_a  = r2_cls_a.exp_ones &  r2_cls_a.frac_zero;
        w_inf_b  = r2_cls_b.exp_ones &  r2_cls_b.frac_zero;
        w_zero_a = r2_cls_a.exp_zero &  r2_cls_a.frac_zero;
        w_zero_b = r2_cls_b.exp_zero &  r2_cls_b.frac_zero;

        if (w_nan_a | w_nan_b | (w_inf_a & w_zero_b) | (w_zero_a & w_inf_b))
            w_mag = C_NAN;
        else if (w_inf_a | w_inf_b)
            w_mag = C_INF;
        else if (w_zero_a | w_zero_b)
            w_mag = C_ZERO;
        else
            w_mag = w_calc;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s       <= '0;
            s_valid <= 1'b0;
        end else if (enable) begin
            s       <= {r2_sign, w_mag};
            s_valid <= r2_valid;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fmul_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fmul_pipe : directed table, corner sequences and random checks    |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module tb_fmul_pipe;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [1:0]  rm = '0;
    logic        fmul = 1'b0, enable = 1'b0;
    logic [31:0] s;
    logic        s_valid;

    fmul_pipe dut (
        .clock(clock), .resetn(resetn), .a(a), .b(b), .rm(rm),
        .fmul(fmul), .enable(enable), .s(s), .s_valid(s_valid)
    );

    always #5 clock = ~clock;

    typedef struct { logic v; logic [31:0] r; int id; } exp_t;
    typedef struct { logic [31:0] a; logic [31:0] b; logic [1:0] rm; logic [31:0] exp; } vec_t;

    exp_t hist[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   op_id = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %08h, required %08h", name, act, req);
        end
    endtask

    // Exact product of two fp32 values, rounded onto the fp32 grid.
    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic [1:0] m);
        logic sg, nx, ny, ix, iy, zx, zy, above, tie, inexact, inc;
        int ex, ey, ep, k, be, d;
        longint unsigned mx, my, p, q, rem, half;
        logic [30:0] mag;
        sg = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        nx = (ex == 255) && (x[22:0] != 0);
        ny = (ey == 255) && (y[22:0] != 0);
        ix = (ex == 255) && (x[22:0] == 0);
        iy = (ey == 255) && (y[22:0] == 0);
        zx = (ex == 0) && (x[22:0] == 0);
        zy = (ey == 0) && (y[22:0] == 0);
        if (nx || ny || (ix && zy) || (zx && iy)) return {sg, 31'h7fc00000};
        if (ix || iy) return {sg, 31'h7f800000};
        if (zx || zy) return {sg, 31'h00000000};
        mx = 64'(x[22:0]);
        my = 64'(y[22:0]);
        if (ex != 0) mx = mx | 64'h800000;
        if (ey != 0) my = my | 64'h800000;
        ep = ((ex == 0) ? -149 : ex - 150) + ((ey == 0) ? -149 : ey - 150);
        p  = mx * my;
        k  = 0;
        for (int i = 0; i < 48; i++) if (p[i]) k = i;
        be = k + ep + 127;
        d  = (be >= 1) ? k - 23 : -149 - ep;
        above = 1'b0; tie = 1'b0; inexact = 1'b0;
        if (d <= 0) begin
            q = p << (-d);
        end else if (d > 60) begin
            q = 0;
            inexact = 1'b1;
        end else begin
            q       = p >> d;
            rem     = p & ((64'd1 << d) - 1);
            half    = 64'd1 << (d - 1);
            above   = rem > half;
            tie     = rem == half;
            inexact = rem != 0;
        end
        case (m)
            2'b00:   inc = above || (tie && q[0]);
            2'b01:   inc = inexact && sg;
            2'b10:   inc = inexact && !sg;
            default: inc = 1'b0;
        endcase
        q = q + 64'(inc);
        if (be >= 1) begin
            if (q == (64'd1 << 24)) begin
                q  = 64'd1 << 23;
                be = be + 1;
            end
            if (be >= 255)
                mag = ((m == 2'b00) || (m == 2'b01 && sg) || (m == 2'b10 && !sg))
                      ? 31'h7f800000 : 31'h7f7fffff;
            else
                mag = {be[7:0], q[22:0]};
        end else begin
            mag = q[30:0];
        end
        return {sg, mag};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 9))
            0: x[30:23] = 8'h00;
            1: begin
                x[30:23] = 8'hff;
                if ($urandom_range(0, 1) == 0) x[22:0] = '0;
            end
            2: x[30:0] = '0;
            3: x[30:23] = 8'($urandom_range(1, 40));
            4: x[30:23] = 8'($urandom_range(200, 254));
            default: x[30:23] = 8'($urandom_range(100, 154));
        endcase
        return x;
    endfunction

    // One clock: drive, take the edge, update the latency model, check.
    task automatic cycle(input logic [31:0] ia, input logic [31:0] ib, input logic [1:0] irm,
                         input logic iv, input logic ien, input logic [31:0] iexp);
        exp_t e;
        a = ia; b = ib; rm = irm; fmul = iv; enable = ien;
        @(posedge clock);
        if (ien) begin
            e.v = iv; e.r = iexp; e.id = op_id;
            if (iv) op_id++;
            hist.push_back(e);
            if (hist.size() > 3) void'(hist.pop_front());
        end
        #1;
        if (hist.size() == 3) begin
            check("s_valid", {31'd0, s_valid}, {31'd0, hist[0].v});
            if (hist[0].v) check($sformatf("s op%0d", hist[0].id), s, hist[0].r);
        end else begin
            check("s_valid fill", {31'd0, s_valid}, 32'd0);
        end
    endtask

    task automatic nop();
        cycle(32'd0, 32'd0, 2'b00, 1'b0, 1'b1, 32'd0);
    endtask

    vec_t tbl[19];

    initial begin
        logic [31:0] x, y;
        logic [1:0]  m;
        tbl[0]  = '{32'h3fc00000, 32'h40000000, 2'b00, 32'h40400000};
        tbl[1]  = '{32'h3f800001, 32'h3f800001, 2'b00, 32'h3f800002};
        tbl[2]  = '{32'h3f800001, 32'h3f800001, 2'b10, 32'h3f800003};
        tbl[3]  = '{32'h3f800001, 32'h3f800001, 2'b11, 32'h3f800002};
        tbl[4]  = '{32'hbf800001, 32'h3f800001, 2'b01, 32'hbf800003};
        tbl[5]  = '{32'h7f000000, 32'h40000000, 2'b00, 32'h7f800000};
        tbl[6]  = '{32'h7f000000, 32'h40000000, 2'b11, 32'h7f7fffff};
        tbl[7]  = '{32'hff000000, 32'h40000000, 2'b10, 32'hff7fffff};
        tbl[8]  = '{32'h7f800000, 32'h00000000, 2'b00, 32'h7fc00000};
        tbl[9]  = '{32'hff800000, 32'h3f800000, 2'b00, 32'hff800000};
        tbl[10] = '{32'h7fc00000, 32'h3f800000, 2'b00, 32'h7fc00000};
        tbl[11] = '{32'h80000000, 32'h40000000, 2'b00, 32'h80000000};
        tbl[12] = '{32'h00800000, 32'h3f000000, 2'b00, 32'h00400000};
        tbl[13] = '{32'h00000001, 32'h4b000000, 2'b00, 32'h00800000};
        tbl[14] = '{32'h00000001, 32'h3f000000, 2'b00, 32'h00000000};
        tbl[15] = '{32'h00000001, 32'h3f000000, 2'b10, 32'h00000001};
        tbl[16] = '{32'h80000001, 32'h3f000000, 2'b01, 32'h80000001};
        tbl[17] = '{32'h007fffff, 32'h3f800001, 2'b00, 32'h00800000};
        tbl[18] = '{32'h3fffffff, 32'h3fffffff, 2'b10, 32'h407fffff};

        repeat (2) @(posedge clock);
        #1;
        check("reset s", s, 32'd0);
        check("reset s_valid", {31'd0, s_valid}, 32'd0);
        resetn = 1'b1;

        // Latency: valid only on the third enabled edge.
        cycle(32'h3fc00000, 32'h40000000, 2'b00, 1'b1, 1'b1, 32'h40400000);
        nop();
        nop();

        foreach (tbl[i]) cycle(tbl[i].a, tbl[i].b, tbl[i].rm, 1'b1, 1'b1, tbl[i].exp);
        repeat (3) nop();

        // Three back-to-back ops, freeze for two cycles mid-flight, then drain.
        for (int i = 0; i < 3; i++) begin
            x = rnd_fp(); y = rnd_fp(); m = 2'($urandom_range(0, 3));
            cycle(x, y, m, 1'b1, 1'b1, ref_mul(x, y, m));
        end
        repeat (2) cycle(rnd_fp(), rnd_fp(), 2'b00, 1'b1, 1'b0, 32'd0);
        repeat (3) nop();

        for (int i = 0; i < 600; i++) begin
            x = rnd_fp(); y = rnd_fp(); m = 2'($urandom_range(0, 3));
            cycle(x, y, m, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0),
                  ref_mul(x, y, m));
        end
        repeat (3) nop();

        // Asynchronous reset with results in flight and s_valid high.
        for (int i = 0; i < 4; i++)
            cycle(32'h3fc00000, 32'h40000000, 2'b00, 1'b1, 1'b1, 32'h40400000);
        resetn = 1'b0;
        #1;
        check("midreset s", s, 32'd0);
        check("midreset s_valid", {31'd0, s_valid}, 32'd0);
        hist.delete();
        @(posedge clock);
        #1;
        resetn = 1'b1;
        repeat (4) nop();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fmul_pipe.md
Name: fmul_pipe

Overview:
Three-stage pipelined IEEE-754 single-precision multiplier. It is the multiply counterpart of the Newton-iteration divider and shares that unit's operand interface, rounding-mode encoding, denormal handling and special-value encoding.
It sits in the FP execution path beside the divider and is driven by the same pipeline enable. It never stalls and accepts one operation per enabled cycle.

Parameters:
ZERO, 31'h00000000, magnitude returned for zero results
INF, 31'h7f800000, infinity magnitude
NaN, 31'h7fc00000, quiet-NaN magnitude
MAX, 31'h7f7fffff, largest finite magnitude

Ports:
clock    in   1   rising-edge clock
resetn   in   1   asynchronous active-low reset
a        in   32  multiplicand (fp32)
b        in   32  multiplier (fp32)
rm       in   2   round mode: 00 nearest-even, 01 toward -inf, 10 toward +inf, 11 toward zero
fmul     in   1   operation valid (ID stage)
enable   in   1   pipeline advance; low freezes every stage
s        out  32  registered product {sign, 31-bit magnitude}
s_valid  out  1   s holds the result of an fmul issued 3 enabled edges earlier

Behaviour:
- Reset (resetn=0, asynchronous) clears all stage registers; s=0 and s_valid=0.
  - Reset mid-operation discards in-flight work with no partial output.
- All registers update only on posedge clock with enable=1. With enable=0, every stage (valid bits included) holds its value.
- Latency is 3 enabled edges, with one issue per enabled edge.
  - A valid bit travels with the data: fmul -> v1 -> v2 -> s_valid.
  - Datapath stages also capture when fmul=0; s_valid marks which results are meaningful.
- E1 (input to reg1): unpack, then normalise the fractions.
  - Fraction is {1,frac} for normal operands and {frac,0} for expo=00 (denormal, the divider convention). Each is shifted so its MSB is 1 and the shift amount is recorded.
  - Exponent: exp10 = ea + eb - 127 + 1 - sha - shb, 10-bit two's complement.
  - Also registered: sign = a[31]^b[31], rm, and the six class flags (expo==00, expo==ff, frac==0 for each operand).
- E2 (reg1 to reg2): 24x24 unsigned product p[47:0]. All E1 side information is forwarded.
- E3 (reg2 to s): final normalisation, denormal shifting, rounding and the special-case mux.
  - If p[47]=1, z=p and e=exp10; otherwise z=p<<1 and e=exp10-1.
  - e<=0 (denormal result): z >>= (1-e) with sticky OR of the shifted-out bits, then exp0=0. A shift of 26 or more leaves only the sticky bit.
  - e>254: force overflow.
  - Keep 24 bits plus guard and round bits plus sticky. Round increment:
    - rm00: round half to even.
    - rm01: increment if any of g/r/s is set and sign=1.
    - rm10: increment if any of g/r/s is set and sign=0.
    - rm11: never increment.
  - A carry out of the rounded mantissa increments the exponent. A denormal that rounds up into 0x800000 becomes exp=1.
  - Overflow when the final exponent is 255 or more. The result then depends on rm and sign:
    - rm00: INF.
    - rm01: sign0 gives MAX, sign1 gives INF.
    - rm10: sign0 gives INF, sign1 gives MAX.
    - rm11: MAX.
  - Special cases have priority over the calculation:
    - Either operand NaN (expo ff, frac!=0): NaN.
    - inf x 0 or 0 x inf: NaN.
    - inf x (normal, denormal or inf): INF.
    - 0 x (finite): ZERO.
    - Otherwise: the calculated result.
  - s = {sign, magnitude}, so NaN carries the XOR sign.
- Underflow to zero keeps the sign, giving -0 for negative products. No exception flags are produced.

Decomposition:
- Shared fp package holds ZERO/INF/NaN/MAX, the rm encodings, and the class-flag decode function, which is reused by the divider.
- The MSB normaliser is the existing shared leading-one shifter, instantiated twice.
- One new sub-module: fmul_mant24, a combinational 24x24 to 48-bit mantissa multiplier (Wallace tree or behavioural *), instantiated in E2.

Test Plan:
- rm=00, issue 3fc00000 x 40000000 with fmul=1 and enable held 1 -> s=40400000 with s_valid=1 on the 3rd edge, s_valid=0 on edges 1-2.
- 3f800001 x 3f800001: rm=00 -> 3f800002; rm=10 -> 3f800003; rm=11 -> 3f800002. bf800001 x 3f800001 with rm=01 -> bf800003.
- 7f000000 x 40000000: rm=00 -> 7f800000; rm=11 -> 7f7fffff. ff000000 x 40000000 with rm=10 -> ff7fffff.
- Specials:
  - 7f800000 x 00000000 -> 7fc00000.
  - ff800000 x 3f800000 -> ff800000.
  - 7fc00000 x 3f800000 -> 7fc00000.
  - 80000000 x 40000000 -> 80000000.
- Denormals, rm=00:
  - 00800000 x 3f000000 -> 00400000.
  - 00000001 x 4b000000 -> 00800000.
  - 00000001 x 3f000000 -> 00000000 (tie to even).
- Back-to-back issue of three ops, then enable=0 for 2 cycles mid-flight -> s/s_valid frozen, and results appear in order once enable returns. Assert resetn low mid-flight -> s=0 and s_valid=0 immediately, with no stale results afterward.
